multichannel_dynamic_delay: RTL and testbench
=============================================

MULTICHANNEL_DYNAMIC_DELAY -- requirements
Module: multichannel_dynamic_delay

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, the number of independent delay channels.
REQ-002 SHALL have parameter WIDTH, default 16, the data bits per channel.
REQ-003 SHALL have parameter LENGTH, default 1024, the history depth in samples; legal range is 2 <= LENGTH <= 2**SEL_W.
REQ-004 SHALL have parameter SEL_W, default 10, the per-channel delay-select width.
REQ-005 SHALL have parameter FILL_W, default SEL_W+1, the fill-counter width; it must hold the value LENGTH.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port ena, input, 1 bit: sample enable, common to all channels.
REQ-009 SHALL have port flush, input, 1 bit: synchronous clear of history state.
REQ-010 SHALL have port in, input, CHANNELS*WIDTH bits: channel c occupies bits [c*WIDTH +: WIDTH].
REQ-011 SHALL have port sel, input, CHANNELS*SEL_W bits: per-channel delay in samples; channel c occupies [c*SEL_W +: SEL_W].
REQ-012 SHALL have port out, output, CHANNELS*WIDTH bits: registered delayed data, packed as in.
REQ-013 SHALL have port out_valid, output, CHANNELS bits: bit c high when out channel c holds a genuinely written sample.
REQ-014 SHALL have port fill, output, FILL_W bits: count of samples written since the last reset or flush, saturating at LENGTH.

Function
REQ-015 SHALL hold one shared write pointer wp, range 0..LENGTH-1, and per-channel history of LENGTH x WIDTH.
REQ-016 SHALL, on an edge with ena=1 and flush=0, write in into history[wp] for every channel, advance wp to (wp+1) mod LENGTH, and advance fill by 1, saturating at LENGTH.
REQ-017 SHALL clamp any sel channel value greater than LENGTH-1 to LENGTH-1 (effective delay d).
REQ-018 SHALL, on an edge with ena=1 and flush=0, load out channel c with the sample written d enabled edges earlier; d=0 loads the sample written on that same edge, giving 1-cycle latency.
REQ-019 SHALL, on the same edge as REQ-018, set out_valid[c] to 1 when the pre-edge fill >= d, else 0; when out_valid[c]=0, out channel c shall be loaded with zero.
REQ-020 SHALL, when ena=0 and flush=0, hold wp, fill, history, out and out_valid unchanged; sel changes while ena=0 have no effect until the next enabled edge.
REQ-021 SHALL evaluate sel per channel independently on every enabled edge; a sel change takes effect on the first enabled edge after the change, with no glitch or intermediate value.
REQ-022 SHALL wrap wp from LENGTH-1 to 0 seamlessly; delays spanning the wrap shall return correct samples.
REQ-023 SHALL give flush=1 priority over ena: on that edge, clear wp, fill, out and out_valid to 0, write nothing, and leave history contents don't-care.
REQ-024 SHALL keep history contents as don't-care after reset or flush; stale data shall never appear with out_valid=1, because of the REQ-019 gating.
REQ-025 SHALL contain no combinational path from in or sel to out, out_valid or fill.

Reset
REQ-026 SHALL, while rst=1, asynchronously force out=0, out_valid=0, fill=0 and wp=0, independent of clk.
REQ-027 SHALL, when rst is asserted mid-operation, discard all history, so that after release behaviour is identical to power-up.
REQ-028 SHALL let history storage be non-reset, to permit RAM or SRL inference.
REQ-029 SHALL accept the first write on the first enabled edge after rst deasserts.

Verification (CHANNELS=2, WIDTH=8, LENGTH=8, SEL_W=3)
REQ-030 SHALL verify: reset, then ena=1 with in ch0=1,2,3,... and sel0=3 -> out_valid[0]=0 for edges 1-3; edge 4 gives out0=1 with valid=1; thereafter out0 = in-3.
REQ-031 SHALL verify: sel0=0 and sel1=7 concurrently over 20 enabled edges -> ch0 output equals the same-edge input; ch1 becomes valid at edge 8 and then lags by 7 across the wp wrap; fill saturates at 8.
REQ-032 SHALL verify: ena toggled 1,0,0,1 pseudo-randomly -> delay is counted in enabled edges only; out, out_valid and fill hold while ena=0.
REQ-033 SHALL verify: flush=1 together with ena=1 after 10 samples -> next edge gives fill=0 and out_valid=0; the following enabled edge with sel=2 gives valid=0 until 2 new samples are written.
REQ-034 SHALL verify: rst pulsed between clock edges mid-stream -> outputs go to 0 immediately with no clock edge; post-release sequence matches the REQ-030 result.
REQ-035 SHALL verify: sel0 switched from 1 to 5 to 0 on consecutive enabled edges -> each edge's output matches a reference model with the per-edge sel; any sel value above LENGTH-1 is clamped to 7.

Source files
------------

// File: rtl/multichannel_dynamic_delay.sv
// Per-channel programmable delay line sharing one write pointer and fill counter.
// Outputs are registered and gated to zero until enough samples exist for the requested delay.
module multichannel_dynamic_delay #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 16,
    parameter int LENGTH   = 1024,
    parameter int SEL_W    = 10,
    parameter int FILL_W   = SEL_W + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ena,
    input  logic                      flush,
    input  logic [CHANNELS*WIDTH-1:0] in,
    input  logic [CHANNELS*SEL_W-1:0] sel,
    output logic [CHANNELS*WIDTH-1:0] out,
    output logic [CHANNELS-1:0]       out_valid,
    output logic [FILL_W-1:0]         fill
);

    localparam logic [SEL_W-1:0]  max_dly  = SEL_W'(LENGTH - 1);
    localparam logic [SEL_W:0]    len_ext  = (SEL_W+1)'(LENGTH);
    localparam logic [FILL_W-1:0] fill_max = FILL_W'(LENGTH);

    logic [SEL_W-1:0]          wp;
    logic [WIDTH-1:0]          hist [CHANNELS][LENGTH];
    logic [SEL_W-1:0]          dly [CHANNELS];
    logic [SEL_W:0]            wrap_idx [CHANNELS];
    logic [SEL_W-1:0]          rd_idx [CHANNELS];
    logic [CHANNELS-1:0]       hit;
    logic [CHANNELS*WIDTH-1:0] next_out;

    // Read index is wp-d modulo LENGTH; d=0 bypasses history and takes this edge's input.
    always_comb begin
        next_out = '0;
        hit      = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            dly[c] = (sel[c*SEL_W +: SEL_W] > max_dly) ? max_dly : sel[c*SEL_W +: SEL_W];
            wrap_idx[c] = len_ext + {1'b0, wp} - {1'b0, dly[c]};
            rd_idx[c] = (wp >= dly[c]) ? (wp - dly[c]) : wrap_idx[c][SEL_W-1:0];
            hit[c] = 32'(fill) >= 32'(dly[c]);
            if (hit[c]) begin
                if (dly[c] == '0)
                    next_out[c*WIDTH +: WIDTH] = in[c*WIDTH +: WIDTH];
                else
                    next_out[c*WIDTH +: WIDTH] = hist[c][rd_idx[c]];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp        <= '0;
            fill      <= '0;
            out       <= '0;
            out_valid <= '0;
        end else if (flush) begin
            wp        <= '0;
            fill      <= '0;
            out       <= '0;
            out_valid <= '0;
        end else if (ena) begin
            wp        <= (wp == max_dly) ? '0 : wp + 1'b1;
            fill      <= (fill == fill_max) ? fill : fill + 1'b1;
            out       <= next_out;
            out_valid <= hit;
        end
    end

    // History has no reset so it can map onto RAM; stale contents are masked by fill.
    always_ff @(posedge clk) begin
        if (ena && !flush) begin
            for (int c = 0; c < CHANNELS; c++)
                hist[c][wp] <= in[c*WIDTH +: WIDTH];
        end
    end

endmodule

// File: tb/tb_multichannel_dynamic_delay.sv
// Self-checking bench: random and directed stimulus against a queue-based model of
// "the sample written d enabled edges ago, valid once at least d samples exist".
module tb_multichannel_dynamic_delay;

    localparam int CH = 2;
    localparam int W  = 8;
    localparam int L  = 8;
    localparam int SW = 3;
    localparam int FW = 4;

    logic            clk = 0;
    logic            rst = 1;
    logic            ena = 0;
    logic            flush = 0;
    logic [CH*W-1:0] in = '0;
    logic [CH*SW-1:0] sel = '0;
    logic [CH*W-1:0] out;
    logic [CH-1:0]   out_valid;
    logic [FW-1:0]   fill;

    int errors = 0;
    int checks = 0;

    logic [CH*W-1:0] samples[$];
    logic [CH*W-1:0] exp_out = '0;
    logic [CH-1:0]   exp_valid = '0;
    int              exp_fill = 0;

    multichannel_dynamic_delay #(
        .CHANNELS(CH), .WIDTH(W), .LENGTH(L), .SEL_W(SW), .FILL_W(FW)
    ) dut (
        .clk(clk), .rst(rst), .ena(ena), .flush(flush), .in(in), .sel(sel),
        .out(out), .out_valid(out_valid), .fill(fill)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        check({tag, ".out"}, 32'(out), 32'(exp_out));
        check({tag, ".valid"}, 32'(out_valid), 32'(exp_valid));
        check({tag, ".fill"}, 32'(fill), 32'(exp_fill));
    endtask

    task automatic modelClear();
        samples.delete();
        exp_out   = '0;
        exp_valid = '0;
        exp_fill  = 0;
    endtask

    // Reference: keep every sample since the last clear; delay d picks the d-th most recent.
    task automatic modelEdge(input logic e, input logic f, input logic [CH*W-1:0] din,
                             input logic [CH*SW-1:0] s);
        int d;
        int n;
        logic [CH*W-1:0] word;
        if (f) begin
            modelClear();
        end else if (e) begin
            samples.push_back(din);
            n = samples.size();
            for (int c = 0; c < CH; c++) begin
                d = int'(s[c*SW +: SW]);
                if (d > L - 1) d = L - 1;
                if (n - 1 >= d) begin
                    word = samples[n-1-d];
                    exp_out[c*W +: W] = word[c*W +: W];
                    exp_valid[c] = 1'b1;
                end else begin
                    exp_out[c*W +: W] = '0;
                    exp_valid[c] = 1'b0;
                end
            end
            exp_fill = (n > L) ? L : n;
        end
    endtask

    task automatic applyStimulus(input logic e, input logic f, input logic [CH*W-1:0] din,
                                 input logic [CH*SW-1:0] s, input string tag);
        ena = e; flush = f; in = din; sel = s;
        @(posedge clk);
        modelEdge(e, f, din, s);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        logic [7:0] r0;
        logic [7:0] r1;
        logic [SW-1:0] s0;
        logic [SW-1:0] s1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        modelClear();
        checkOutput("reset");
        #2 rst = 0;

        // Fixed delay of 3 on ch0 with ramp input
        for (int k = 1; k <= 12; k++) begin
            r1 = 8'($urandom);
            applyStimulus(1'b1, 1'b0, {r1, 8'(k)}, {3'd0, 3'd3}, "ramp_sel3");
            if (k == 3) check("ramp_edge3_valid0", 32'(out_valid[0]), 32'd0);
            if (k == 4) check("ramp_edge4_out0", 32'(out[7:0]), 32'd1);
        end

        // sel0=0 and sel1=7 across the wrap
        applyStimulus(1'b1, 1'b1, '0, '0, "flush_pre_wrap");
        for (int k = 1; k <= 20; k++) begin
            applyStimulus(1'b1, 1'b0, 16'($urandom), {3'd7, 3'd0}, "wrap_0_7");
            if (k == 7) check("wrap_edge7_valid1", 32'(out_valid[1]), 32'd0);
            if (k == 8) check("wrap_edge8_valid1", 32'(out_valid[1]), 32'd1);
        end
        check("wrap_fill_sat", 32'(fill), 32'd8);

        // Random enable gaps and sel changes
        for (int k = 0; k < 40; k++) begin
            s0 = SW'($urandom); s1 = SW'($urandom);
            applyStimulus(1'($urandom_range(0, 1)), 1'b0, 16'($urandom), {s1, s0}, "rand_ena");
        end

        // Flush together with enable after 10 samples
        applyStimulus(1'b1, 1'b1, '0, '0, "flush_start");
        for (int k = 0; k < 10; k++)
            applyStimulus(1'b1, 1'b0, 16'($urandom), {3'd2, 3'd2}, "pre_flush");
        applyStimulus(1'b1, 1'b1, 16'($urandom), {3'd2, 3'd2}, "flush_ena");
        check("flush_fill0", 32'(fill), 32'd0);
        for (int k = 0; k < 4; k++)
            applyStimulus(1'b1, 1'b0, 16'($urandom), {3'd2, 3'd2}, "post_flush");

        // Asynchronous reset between edges
        for (int k = 0; k < 5; k++)
            applyStimulus(1'b1, 1'b0, 16'($urandom), {3'd1, 3'd0}, "pre_rst");
        #2 rst = 1; ena = 0;
        #1;
        modelClear();
        checkOutput("async_rst");
        @(posedge clk);
        #3 rst = 0;
        for (int k = 1; k <= 6; k++) begin
            r1 = 8'($urandom);
            applyStimulus(1'b1, 1'b0, {r1, 8'(k)}, {3'd0, 3'd3}, "replay_sel3");
            if (k == 4) check("replay_edge4_out0", 32'(out[7:0]), 32'd1);
        end

        // Consecutive sel switches 1 -> 5 -> 0, then random sel
        for (int k = 0; k < 3; k++) begin
            r0 = 8'($urandom);
            s0 = (k == 0) ? 3'd1 : (k == 1) ? 3'd5 : 3'd0;
            applyStimulus(1'b1, 1'b0, {8'($urandom), r0}, {3'd7, s0}, "sel_switch");
        end
        for (int k = 0; k < 16; k++) begin
            s0 = SW'($urandom); s1 = SW'($urandom);
            applyStimulus(1'b1, 1'b0, 16'($urandom), {s1, s0}, "rand_sel");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
